// File: rtl/mult_pkg.sv
// Shared types and helpers for the Booth multiplier partitions.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_e;

  function automatic int calc_n_iter(input int width);
    return (width + 2) / 2;
  endfunction

  // Radix-4 recoding of the window {b[2i+1], b[2i], b[2i-1]}.
  function automatic digit_e booth_decode(input logic [2:0] win);
    digit_e d;
    case (win)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational radix-4 Booth partial product: digit * ext_a, shifted by 2*idx,
// with optional truncation of the low APPROX_COLS columns.
module booth_pp_gen
  import mult_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4,
  parameter int IDX_W       = 3
) (
  input  logic [2:0]           win_i,
  input  logic [WIDTH+1:0]     ext_a_i,
  input  logic [IDX_W-1:0]     idx_i,
  input  logic                 approx_i,
  output logic [2*WIDTH+1:0]   pp_o
);

  localparam int PW = 2*WIDTH + 2;
  localparam logic [PW-1:0] LOW_MASK =
    (APPROX_COLS == 0) ? '0 : ({PW{1'b1}} >> (PW - APPROX_COLS));

  logic [PW-1:0] a_w;
  logic [PW-1:0] mag;
  logic [PW-1:0] shifted;

  assign a_w = {{WIDTH{ext_a_i[WIDTH+1]}}, ext_a_i};

  always_comb begin
    mag = '0;
    case (booth_decode(win_i))
      POS1:    mag = a_w;
      POS2:    mag = a_w << 1;
      NEG1:    mag = -a_w;
      NEG2:    mag = -(a_w << 1);
      default: mag = '0;
    endcase
  end

  assign shifted = mag << {idx_i, 1'b0};
  assign pp_o    = approx_i ? (shifted & ~LOW_MASK) : shifted;

endmodule

// File: rtl/mult_booth_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle, valid/ready
// operand and product streams, signed/unsigned and approximate modes.
module mult_booth_seq
  import mult_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  input  logic                 approx_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 out_approx
);

  localparam int N_ITER = calc_n_iter(WIDTH);
  localparam int PW     = 2*WIDTH + 2;
  localparam int CW     = $clog2(N_ITER + 1);

  state_e            state_q, state_d;
  logic [WIDTH+1:0]  a_q, a_d;
  logic [WIDTH+1:0]  b_q, b_d;
  logic              approx_q, approx_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [WIDTH+4:0]  b_pad;
  logic [CW:0]       win_base;
  logic [2:0]        win;
  logic [PW-1:0]     pp;

  // Padding below supplies bit -1 = 0; padding above keeps the window in range.
  assign b_pad    = {2'b00, b_q, 1'b0};
  assign win_base = {cnt_q, 1'b0};
  assign win      = b_pad[win_base +: 3];

  booth_pp_gen #(
    .WIDTH       (WIDTH),
    .APPROX_COLS (APPROX_COLS),
    .IDX_W       (CW)
  ) u_pp_gen (
    .win_i    (win),
    .ext_a_i  (a_q),
    .idx_i    (cnt_q),
    .approx_i (approx_q),
    .pp_o     (pp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      approx_q <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      approx_q <= approx_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    approx_d = approx_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
          b_d      = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
          approx_d = approx_en;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        // Digits 0..N_ITER-1 accumulate; the extra terminal cycle sets the
        // fixed N_ITER+1 cycle latency to out_valid.
        if (cnt_q == CW'(N_ITER)) begin
          state_d = DONE;
        end else begin
          acc_d = acc_q + pp;
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign p          = out_valid ? acc_q[2*WIDTH-1:0] : '0;
  assign out_approx = out_valid & approx_q;

endmodule
